// File: rtl/pe_tile_sched.sv
// pe_tile_sched: sequences one K-accumulation job over a PE array.
// Each K-step requests an operand tile, issues it to the array, and waits for
// the array result. The first issue of a job clears the accumulator.
// After the last step the result is held until the consumer accepts it.
// Optional feature macro: PE_SCHED_TIMEOUT_EN. When it is defined, a watchdog
// in WAIT_RES aborts a stalled job and sets a sticky err flag.
module pe_tile_sched #(
    parameter int unsigned KCNT_W = 8,
    parameter int unsigned TO_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [KCNT_W-1:0] k_tiles,
    input  logic [1:0]        mode_cfg,
    output logic              op_req,
    input  logic              op_valid,
    output logic [1:0]        pe_mode,
    output logic              arr_valid_in,
    output logic              acc_clr,
    input  logic              arr_valid_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_OP  = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT_RES = 3'd3,
        S_OUT      = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [KCNT_W-1:0]   r_k_cnt;
    logic [KCNT_W-1:0]   r_k_lat;
    logic [1:0]          r_mode;
    logic                r_op_req;
    logic                r_arr_valid_in;
    logic                r_acc_clr;
    logic                r_res_valid;
    logic                r_busy;
    logic                r_done;
    logic                w_start_acc;
    logic                w_last_step;
    logic                w_to_fire;

    // A start is only honoured in IDLE; everything else ignores it.
    assign w_start_acc = (r_state == S_IDLE) && start;
    // k_lat is never zero in WAIT_RES, so k_lat-1 cannot underflow.
    assign w_last_step = (r_k_cnt == KCNT_W'(r_k_lat - KCNT_W'(1)));

`ifdef PE_SCHED_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_ONES = '1;
    // Fire on the edge where the counter would become all-ones.
    localparam logic [TO_W-1:0] TO_LAST = TO_ONES - TO_W'(1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    assign w_to_fire = (r_state == S_WAIT_RES) && !arr_valid_out && (r_to_cnt == TO_LAST);
    assign err       = r_err;

    // Watchdog counter runs only in WAIT_RES and restarts at zero on each entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state != S_WAIT_RES) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Sticky error: set by a watchdog abort, cleared by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_to_fire) begin
            r_err <= 1'b1;
        end else if (w_start_acc) begin
            r_err <= 1'b0;
        end
    end
`else
    // No watchdog: WAIT_RES waits forever and err is constant low.
    assign w_to_fire = 1'b0;
    assign err       = |{TO_W{1'b0}};
`endif

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (k_tiles == '0) ? S_DONE : S_WAIT_OP;
                end
            end
            S_WAIT_OP: begin
                if (op_valid) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (arr_valid_out) begin
                    w_state_nxt = w_last_step ? S_OUT : S_WAIT_OP;
                end else if (w_to_fire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, job context and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_k_cnt        <= '0;
            r_k_lat        <= '0;
            r_mode         <= 2'd0;
            r_op_req       <= 1'b0;
            r_arr_valid_in <= 1'b0;
            r_acc_clr      <= 1'b0;
            r_res_valid    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_op_req       <= (w_state_nxt == S_WAIT_OP);
            r_arr_valid_in <= (w_state_nxt == S_ISSUE);
            // k_cnt is stable across WAIT_OP->ISSUE, so it is safe to test here.
            r_acc_clr      <= (w_state_nxt == S_ISSUE) && (r_k_cnt == '0);
            r_res_valid    <= (w_state_nxt == S_OUT);
            r_busy         <= (w_state_nxt != S_IDLE);
            r_done         <= (w_state_nxt == S_DONE);
            if (w_start_acc) begin
                r_k_lat <= k_tiles;
                r_mode  <= mode_cfg;
                r_k_cnt <= '0;
            end else if ((r_state == S_WAIT_RES) && arr_valid_out && !w_last_step) begin
                r_k_cnt <= r_k_cnt + KCNT_W'(1);
            end
        end
    end

    assign op_req       = r_op_req;
    assign pe_mode      = r_mode;
    assign arr_valid_in = r_arr_valid_in;
    assign acc_clr      = r_acc_clr;
    assign res_valid    = r_res_valid;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_pe_tile_sched.sv
// Bench for pe_tile_sched: a 1-cycle PE model, an event monitor, and a
// scoreboard of per-job expectations popped when each job completes.
module tb_pe_tile_sched;

    localparam int unsigned KCNT_W = 8;
    localparam int unsigned TO_W   = 8;

    logic              clk           = 1'b0;
    logic              rst_n         = 1'b0;
    logic              start         = 1'b0;
    logic [KCNT_W-1:0] k_tiles       = '0;
    logic [1:0]        mode_cfg      = 2'd0;
    logic              op_req;
    logic              op_valid      = 1'b1;
    logic [1:0]        pe_mode;
    logic              arr_valid_in;
    logic              acc_clr;
    logic              arr_valid_out;
    logic              res_valid;
    logic              res_ready     = 1'b1;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pe_tile_sched #(.KCNT_W(KCNT_W), .TO_W(TO_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_tiles(k_tiles),
        .mode_cfg(mode_cfg), .op_req(op_req), .op_valid(op_valid),
        .pe_mode(pe_mode), .arr_valid_in(arr_valid_in), .acc_clr(acc_clr),
        .arr_valid_out(arr_valid_out), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy), .done(done), .err(err)
    );

    // PE array model: result-valid one cycle after issue; stray_avo injects spurious strobes.
    logic pe_en = 1'b1;
    logic pe_avo = 1'b0;
    logic stray_avo = 1'b0;
    always @(posedge clk) pe_avo <= pe_en & arr_valid_in;
    assign arr_valid_out = pe_avo | stray_avo;

    // Event monitor; mon_clr restarts counting from the current cycle.
    logic       mon_clr  = 1'b0;
    logic [1:0] mon_mode = 2'd0;
    int m_issue, m_clr, m_clr_bad, m_busy, m_resv, m_opreq, m_done, m_mode_bad;
    always @(negedge clk) begin : mon
        int ib;
        ib = mon_clr ? 0 : m_issue;
        m_issue    <= ib + (arr_valid_in ? 1 : 0);
        m_clr      <= (mon_clr ? 0 : m_clr) + ((arr_valid_in && acc_clr) ? 1 : 0);
        m_clr_bad  <= (mon_clr ? 0 : m_clr_bad) + ((acc_clr && (!arr_valid_in || ib != 0)) ? 1 : 0);
        m_busy     <= (mon_clr ? 0 : m_busy) + (busy ? 1 : 0);
        m_resv     <= (mon_clr ? 0 : m_resv) + (res_valid ? 1 : 0);
        m_opreq    <= (mon_clr ? 0 : m_opreq) + (op_req ? 1 : 0);
        m_done     <= (mon_clr ? 0 : m_done) + (done ? 1 : 0);
        m_mode_bad <= (mon_clr ? 0 : m_mode_bad) + ((busy && pe_mode != mon_mode) ? 1 : 0);
    end

    typedef struct {
        int         k;
        int         issue;
        int         clr;
        int         busy;
        int         resv;
        int         opreq;
        logic [1:0] mode;
    } exp_t;
    exp_t exp_q[$];

    // Push the job's expectations and pulse start (sampled on the next rising edge).
    task automatic launch(input int k, input logic [1:0] mode, input int extra_busy,
                          input int extra_opreq, input int out_cycles);
        exp_t e;
        e.k     = k;
        e.issue = k;
        e.clr   = (k == 0) ? 0 : 1;
        e.busy  = (k == 0) ? 1 : 3 * k + out_cycles + 1 + extra_busy;
        e.resv  = (k == 0) ? 0 : out_cycles;
        e.opreq = (k == 0) ? 0 : k + extra_opreq;
        e.mode  = mode;
        exp_q.push_back(e);
        mon_clr  = 1'b1;
        mon_mode = mode;
        start    = 1'b1;
        k_tiles  = KCNT_W'(k);
        mode_cfg = mode;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        mon_clr = 1'b0;
    endtask

    // Wait (bounded) for done, then pop the expectation and compare the job record.
    task automatic wait_job(input string name);
        exp_t e;
        int   cyc;
        cyc = 0;
        while (m_done == 0 && cyc < 3000) begin
            @(negedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (m_done == 0) begin
            n_fail++;
            $display("FAIL %s_done_timeout: no done within %0d cycles", name, cyc);
        end
        @(negedge clk); #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_scoreboard: no expected entry queued", name);
            return;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (m_issue !== e.issue) begin n_fail++; $display("FAIL %s_issues: got %0d want %0d", name, m_issue, e.issue); end
        n_checks++;
        if (m_clr !== e.clr) begin n_fail++; $display("FAIL %s_acc_clr: got %0d want %0d", name, m_clr, e.clr); end
        n_checks++;
        if (m_clr_bad !== 0) begin n_fail++; $display("FAIL %s_acc_clr_misplaced: got %0d want 0", name, m_clr_bad); end
        n_checks++;
        if (m_busy !== e.busy) begin n_fail++; $display("FAIL %s_busy_cycles: got %0d want %0d", name, m_busy, e.busy); end
        n_checks++;
        if (m_resv !== e.resv) begin n_fail++; $display("FAIL %s_res_valid_cycles: got %0d want %0d", name, m_resv, e.resv); end
        n_checks++;
        if (m_opreq !== e.opreq) begin n_fail++; $display("FAIL %s_op_req_cycles: got %0d want %0d", name, m_opreq, e.opreq); end
        n_checks++;
        if (m_done !== 1) begin n_fail++; $display("FAIL %s_done_pulses: got %0d want 1", name, m_done); end
        n_checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL %s_idle_after: busy=%b err=%b want 0 0", name, busy, err); end
        if (e.k != 0) begin
            n_checks++;
            if (m_mode_bad !== 0 || pe_mode !== e.mode) begin
                n_fail++;
                $display("FAIL %s_pe_mode: bad_cycles=%0d pe_mode=%0d want %0d", name, m_mode_bad, pe_mode, e.mode);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({op_req, arr_valid_in, acc_clr, res_valid, busy, done, err, pe_mode} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0", {op_req, arr_valid_in, acc_clr, res_valid, busy, done, err, pe_mode});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({op_req, busy, done, err} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b want 0", {op_req, busy, done, err});
        end
    endtask

    task automatic test_basic();
        launch(4, 2'd1, 0, 0, 1);
        wait_job("basic_k4");
    endtask

    task automatic test_zero_k();
        launch(0, 2'd3, 0, 0, 1);
        wait_job("zero_k");
    endtask

    task automatic test_res_hold();
        int cyc;
        res_ready = 1'b0;
        launch(2, 2'd0, 0, 0, 10);
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
        end
        repeat (9) @(posedge clk);
        #1 res_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (res_valid !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL res_hold_last_out: res_valid=%b done=%b want 1 0", res_valid, done);
        end
        @(negedge clk); #1;
        n_checks++;
        if (done !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL res_hold_done_after_ready: done=%b res_valid=%b want 1 0", done, res_valid);
        end
        wait_job("res_hold");
    endtask

    task automatic test_mode_and_busy_start();
        launch(3, 2'd2, 0, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        mode_cfg = 2'd1;
        k_tiles  = KCNT_W'(5);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_job("mode_hold");
        mon_clr = 1'b1;
        @(negedge clk); #1;
        mon_clr = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if (m_busy !== 0 || pe_mode !== 2'd2) begin
            n_fail++;
            $display("FAIL busy_start_ignored: busy_cycles=%0d pe_mode=%0d want 0 2", m_busy, pe_mode);
        end
    endtask

    task automatic test_stray_and_op_gap();
        stray_avo = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || op_req !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_in_idle: busy=%b op_req=%b want 0 0", busy, op_req);
        end
        op_valid = 1'b0;
        launch(2, 2'd1, 5, 5, 1);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (op_req !== 1'b1 || m_issue !== 0) begin
            n_fail++;
            $display("FAIL stray_in_wait_op: op_req=%b issues=%0d want 1 0", op_req, m_issue);
        end
        stray_avo = 1'b0;
        op_valid  = 1'b1;
        wait_job("op_gap");
    endtask

    task automatic test_max_k();
        launch(255, 2'd3, 0, 0, 1);
        wait_job("max_k");
    endtask

    task automatic test_reset_mid_job();
        int cyc;
        launch(3, 2'd3, 0, 0, 1);
        cyc = 0;
        while (m_issue < 2 && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({op_req, arr_valid_in, acc_clr, res_valid, busy, done, err, pe_mode} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b want 0", {op_req, arr_valid_in, acc_clr, res_valid, busy, done, err, pe_mode});
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (m_done !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got %0d want 0", m_done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        launch(2, 2'd1, 0, 0, 1);
        wait_job("after_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            launch(int'($urandom_range(1, 6)), 2'($urandom_range(0, 3)), 0, 0, 1);
            wait_job("back_to_back");
        end
    endtask

`ifdef PE_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        pe_en = 1'b0;
        launch(1, 2'd1, 0, 0, 1);
        cyc = 0;
        while (arr_valid_in !== 1'b1 && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
        end
        @(posedge clk);
        repeat (254) @(posedge clk);
        #1;
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: err=%b busy=%b want 0 1", err, busy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || m_done !== 0) begin
            n_fail++;
            $display("FAIL timeout_fire: err=%b busy=%b done_pulses=%0d want 1 0 0", err, busy, m_done);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        pe_en = 1'b1;
        @(negedge clk); #1;
        launch(1, 2'd2, 0, 0, 1);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_err_clear: got %b want 0", err);
        end
        wait_job("after_timeout");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_k();
        test_res_hold();
        test_mode_and_busy_start();
        test_stray_and_op_gap();
        test_max_k();
        test_reset_mid_job();
        test_back_to_back();
`ifdef PE_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule
